wb_stage: RTL and testbench

//   Write-back stage of the 5-stage MIPS pipeline: MEM/WB pipeline register plus result/destination select.

---
 rtl/wb_stage.sv | 157 +++++++++++++++
 tb/tb_wb_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, destination/data select for the
// register-file write port, retired-instruction counter and halt/drain sequencer.
module wb_stage #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             validM,
  input  logic             haltM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             RegDstM,
  input  logic             JumpLinkM,
  input  logic [4:0]       rt_addr_M,
  input  logic [4:0]       rd_addr_M,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      ReadDataM,
  input  logic [31:0]      PCPlus4M,
  output logic             RegWriteW,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retire_count,
  output logic             halted
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] drain_cnt;

  logic          valid_w;
  logic          halt_w;
  logic          reg_write_w;
  logic          mem_to_reg_w;
  logic          reg_dst_w;
  logic          jump_link_w;
  logic [4:0]    rt_w;
  logic [4:0]    rd_w;
  logic [31:0]   alu_out_w;
  logic [31:0]   read_data_w;
  logic [31:0]   pc_plus4_w;

  logic          running;
  logic          load;
  logic [4:0]    dest;
  logic [31:0]   data;

  assign running = (state == ST_RUN);
  // Outside RUN the register free-runs (stall/flush ignored) but only ever holds bubbles.
  assign load    = !running || (!stall && !flush);

  always_ff @(posedge CLK) begin
    if (reset) begin
      valid_w      <= 1'b0;
      halt_w       <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      reg_dst_w    <= 1'b0;
      jump_link_w  <= 1'b0;
      rt_w         <= '0;
      rd_w         <= '0;
      alu_out_w    <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
    end else if (running && flush) begin
      valid_w      <= 1'b0;
      halt_w       <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      reg_dst_w    <= 1'b0;
      jump_link_w  <= 1'b0;
      rt_w         <= '0;
      rd_w         <= '0;
      alu_out_w    <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
    end else if (load) begin
      valid_w      <= validM && running;
      halt_w       <= haltM;
      reg_write_w  <= RegWriteM;
      mem_to_reg_w <= MemtoRegM;
      reg_dst_w    <= RegDstM;
      jump_link_w  <= JumpLinkM;
      rt_w         <= rt_addr_M;
      rd_w         <= rd_addr_M;
      alu_out_w    <= ALUOutM;
      read_data_w  <= ReadDataM;
      pc_plus4_w   <= PCPlus4M;
    end
  end

  // An entry is counted as it leaves WB, so a held (stalled) entry counts once.
  always_ff @(posedge CLK) begin
    if (reset) begin
      retire_count <= '0;
    end else if (running && !stall && !flush && valid_w && !halt_w) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (valid_w && halt_w) begin
            if (DRAIN_CYCLES == 0) begin
              state <= ST_HALTED;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DW'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) begin
            state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    dest = rt_w;
    data = alu_out_w;
    if (jump_link_w) begin
      dest = 5'd31;
      data = pc_plus4_w;
    end else begin
      if (reg_dst_w)    dest = rd_w;
      if (mem_to_reg_w) data = read_data_w;
    end
  end

  assign wb_addr   = dest;
  assign wb_data   = data;
  assign RegWriteW = valid_w && reg_write_w && !halt_w && (dest != 5'd0) && running;
  assign halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for the select/enable logic plus
// hand-written sequences for stall/flush, halt drain, reset-in-drain and wrap.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        validM, haltM, RegWriteM, MemtoRegM, RegDstM, JumpLinkM;
  logic [4:0]  rt_addr_M, rd_addr_M;
  logic [31:0] ALUOutM, ReadDataM, PCPlus4M;

  logic        RegWriteW, halted;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_count;

  logic        we2, halted2;
  logic [4:0]  addr2;
  logic [31:0] data2;
  logic [1:0]  count2;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  wb_stage #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
    .CLK(CLK), .reset(reset), .stall(stall), .flush(flush),
    .validM(validM), .haltM(haltM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .RegDstM(RegDstM), .JumpLinkM(JumpLinkM), .rt_addr_M(rt_addr_M), .rd_addr_M(rd_addr_M),
    .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_count(retire_count), .halted(halted)
  );

  // Second instance: immediate halt and a 2-bit counter that wraps quickly.
  wb_stage #(.DRAIN_CYCLES(0), .CNT_W(2)) dut_wrap (
    .CLK(CLK), .reset(reset), .stall(stall), .flush(flush),
    .validM(validM), .haltM(haltM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .RegDstM(RegDstM), .JumpLinkM(JumpLinkM), .rt_addr_M(rt_addr_M), .rd_addr_M(rd_addr_M),
    .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .RegWriteW(we2), .wb_addr(addr2), .wb_data(data2),
    .retire_count(count2), .halted(halted2)
  );

  typedef struct {
    logic        valid, halt, rw, m2r, rdst, jl, flush;
    logic [4:0]  rt, rd;
    logic [31:0] alu, rdata, pc4;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic valid, logic halt, logic rw, logic m2r, logic rdst,
                              logic jl, logic [4:0] rt, logic [4:0] rd, logic [31:0] alu,
                              logic [31:0] rdata, logic [31:0] pc4, logic fl,
                              logic exp_we, logic [4:0] exp_addr, logic [31:0] exp_data);
    vec_t v;
    v.valid = valid; v.halt = halt; v.rw = rw; v.m2r = m2r; v.rdst = rdst; v.jl = jl;
    v.rt = rt; v.rd = rd; v.alu = alu; v.rdata = rdata; v.pc4 = pc4; v.flush = fl;
    v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ins(input logic valid, input logic halt, input logic rw, input logic m2r,
                         input logic rdst, input logic jl, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4);
    validM = valid; haltM = halt; RegWriteM = rw; MemtoRegM = m2r; RegDstM = rdst;
    JumpLinkM = jl; rt_addr_M = rt; rd_addr_M = rd; ALUOutM = alu; ReadDataM = rdata;
    PCPlus4M = pc4;
  endtask

  task automatic put_add(input logic [4:0] rd, input logic [31:0] alu);
    set_ins(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, rd, alu, 32'h0, 32'h0);
  endtask

  task automatic put_halt;
    set_ins(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 32'hFFFF, 32'h0, 32'h0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic chk_port(input string name, input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
    chk({name, ".we"},   {31'h0, RegWriteW}, {31'h0, we});
    chk({name, ".addr"}, {27'h0, wb_addr},   {27'h0, addr});
    chk({name, ".data"}, wb_data,            data);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_ins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    // valid halt rw m2r rdst jl rt rd alu rdata pc4 flush | we addr data
    tbl[0] = mk(1,0,1,1,0,0, 5'd8, 5'd0,  32'h111,       32'hDEAD_BEEF, 32'h0,   0, 1, 5'd8,  32'hDEAD_BEEF);
    tbl[1] = mk(1,0,1,0,1,0, 5'd3, 5'd9,  32'h5,         32'h0,         32'h0,   0, 1, 5'd9,  32'h5);
    tbl[2] = mk(1,0,1,0,0,1, 5'd0, 5'd7,  32'h99,        32'h0,         32'h44,  0, 1, 5'd31, 32'h44);
    tbl[3] = mk(1,0,1,0,0,0, 5'd0, 5'd0,  32'h77,        32'h0,         32'h0,   0, 0, 5'd0,  32'h77);
    tbl[4] = mk(1,0,0,0,0,0, 5'd5, 5'd0,  32'h1000,      32'h0,         32'h0,   0, 0, 5'd5,  32'h1000);
    tbl[5] = mk(0,0,1,0,0,0, 5'd4, 5'd0,  32'hAB,        32'h0,         32'h0,   0, 0, 5'd4,  32'hAB);
    tbl[6] = mk(1,0,1,0,1,0, 5'd6, 5'd13, 32'h1234,      32'h0,         32'h0,   1, 0, 5'd0,  32'h0);
    tbl[7] = mk(1,0,1,0,1,0, 5'd1, 5'd17, 32'h0F0F_0F0F, 32'h0,         32'h0,   0, 1, 5'd17, 32'h0F0F_0F0F);
    tbl[8] = mk(1,0,1,1,0,1, 5'd2, 5'd3,  32'h2,         32'h1,         32'h100, 0, 1, 5'd31, 32'h100);
    tbl[9] = mk(1,0,1,0,1,0, 5'd12,5'd0,  32'h3C,        32'h0,         32'h0,   0, 0, 5'd0,  32'h3C);

    // Two reset cycles, then check reset state.
    tick; tick;
    reset = 1'b0;
    chk_port("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.count",  retire_count, 32'h0);
    chk("reset.halted", {31'h0, halted}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      set_ins(tbl[i].valid, tbl[i].halt, tbl[i].rw, tbl[i].m2r, tbl[i].rdst, tbl[i].jl,
              tbl[i].rt, tbl[i].rd, tbl[i].alu, tbl[i].rdata, tbl[i].pc4);
      flush = tbl[i].flush;
      tick;
      chk_port($sformatf("vec%0d", i), tbl[i].exp_we, tbl[i].exp_addr, tbl[i].exp_data);
    end
    flush = 1'b0;
    // Entries 0-4,7,8 have left via loads; the flush edge retires nothing.
    chk("table.count", retire_count, 32'd7);
    chk("table.count2", {30'h0, count2}, 32'd3);

    // Held instruction under stall: write stays up, counted once.
    put_add(5'd10, 32'h55);
    tick;
    chk("add.count", retire_count, 32'd8);
    chk("wrap.count2", {30'h0, count2}, 32'd0);
    stall = 1'b1;
    put_add(5'd11, 32'h66);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_port($sformatf("stall%0d", i), 1'b1, 5'd10, 32'h55);
      chk($sformatf("stall%0d.count", i), retire_count, 32'd8);
    end
    stall = 1'b0;
    set_ins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd0, 32'hCC, 32'h0, 32'h0);
    tick;
    chk_port("unstall", 1'b0, 5'd6, 32'hCC);
    chk("unstall.count", retire_count, 32'd9);
    stall = 1'b1; flush = 1'b1;
    put_add(5'd12, 32'h88);
    tick;
    chk_port("flush_stall", 1'b0, 5'd0, 32'h0);
    chk("flush_stall.count", retire_count, 32'd9);
    stall = 1'b0; flush = 1'b0;

    // Halt after three instructions with a 4-cycle drain.
    do_reset;
    chk("rst2.count", retire_count, 32'd0);
    put_add(5'd1, 32'h1); tick;
    put_add(5'd2, 32'h2); tick;
    put_add(5'd3, 32'h3); tick;
    put_halt; tick;
    chk_port("halt_in_wb", 1'b0, 5'd5, 32'hFFFF);
    chk("halt_in_wb.count", retire_count, 32'd3);
    put_add(5'd20, 32'h20);
    tick;
    chk("drain0.halted", {31'h0, halted}, 32'h0);
    chk("drain0.we", {31'h0, RegWriteW}, 32'h0);
    chk("d0halt.halted2", {31'h0, halted2}, 32'h1);
    for (int i = 1; i < 4; i++) begin
      if (i == 2) put_halt; else put_add(5'd21, 32'h21);
      stall = (i == 1); flush = (i == 3);
      tick;
      chk($sformatf("drain%0d.halted", i), {31'h0, halted}, 32'h0);
      chk($sformatf("drain%0d.we", i), {31'h0, RegWriteW}, 32'h0);
    end
    stall = 1'b0; flush = 1'b0;
    put_add(5'd22, 32'h22);
    tick;
    chk("halted.rise", {31'h0, halted}, 32'h1);
    chk("halted.count", retire_count, 32'd3);
    tick;
    chk("halted.sticky", {31'h0, halted}, 32'h1);
    chk("halted.we", {31'h0, RegWriteW}, 32'h0);
    chk("halted.count2", {30'h0, count2}, 32'd3);

    // Reset on the second drain cycle returns to RUN.
    do_reset;
    put_add(5'd4, 32'h4); tick;
    put_halt; tick;
    put_add(5'd23, 32'h23); tick;
    tick;
    chk("drain_rst.pre_count", retire_count, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("drain_rst.halted", {31'h0, halted}, 32'h0);
    chk("drain_rst.count", retire_count, 32'd0);
    chk_port("drain_rst", 1'b0, 5'd0, 32'h0);
    chk("drain_rst.halted2", {31'h0, halted2}, 32'h0);
    put_add(5'd7, 32'h77);
    tick;
    chk_port("after_rst", 1'b1, 5'd7, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
